mii_rx_fcs_check: RTL and testbench

Receive-side counterpart of the nibble-wide CRC-32 generator used on the 100M MII transmit path. It consumes raw MII receive nibbles and strips the preamble and SFD. It assembles bytes, checks the IEEE 802.3 FCS with an internal 4-bit-per-cycle CRC-32, removes the 4 FCS bytes from the forwarded stream, and reports per-frame status. It sits between the MII RX pins (after synchronisation) and the RX MAC buffer.

---
 rtl/mii_rx_fcs_check.sv | 172 +++++++++++++++++
 tb/tb_mii_rx_fcs_check.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_fcs_check.sv
// mii_rx_fcs_check: MII receive front end. Strips preamble/SFD, assembles bytes,
// checks the Ethernet FCS with a nibble-serial CRC-32, withholds the four FCS bytes
// from the forwarded stream and reports per-frame status on an end-of-frame strobe.
module mii_rx_fcs_check #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Rx_dv,
    input  logic        Rx_er,
    input  logic [3:0]  Rxd,
    output logic [7:0]  Rx_data,
    output logic        Rx_valid,
    output logic        Rx_sof,
    output logic        Rx_eof,
    output logic        Frame_good,
    output logic [4:0]  Frame_status,
    output logic [10:0] Frame_len
);

    localparam int unsigned CNT_W       = 12;
    localparam int unsigned LEN_W       = 11;
    localparam int unsigned DLINE_DEPTH = 4;
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_DATA     = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    state_t                r_state;
    logic [31:0]           r_crc;
    logic [3:0]            r_lo_nib;
    logic                  r_nib_hi;
    logic [CNT_W-1:0]      r_byte_cnt;
    logic [3:0][7:0]       r_dline;
    logic [2:0]            r_dline_cnt;
    logic                  r_first;
    logic                  r_err_rxer;

    logic [31:0]           w_crc_next;
    logic [7:0]            w_byte;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [CNT_W-1:0]      w_len_raw;
    logic [LEN_W-1:0]      w_len;
    logic [4:0]            w_status;
    logic                  w_dline_full;

    // Shift one nibble, bit 0 first, through the CRC-32 register.
    function automatic logic [31:0] crc_nibble(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[31] ^ nib[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Next CRC, byte assembly, saturating counts and end-of-frame status terms.
    always_comb begin
        w_crc_next   = crc_nibble(r_crc, Rxd);
        w_byte       = {Rxd, r_lo_nib};
        w_cnt_inc    = (r_byte_cnt == {CNT_W{1'b1}}) ? r_byte_cnt : r_byte_cnt + CNT_W'(1);
        w_len_raw    = (r_byte_cnt < CNT_W'(4)) ? '0 : r_byte_cnt - CNT_W'(4);
        w_len        = (w_len_raw > CNT_W'(2047)) ? {LEN_W{1'b1}} : w_len_raw[LEN_W-1:0];
        w_dline_full = (r_dline_cnt == 3'(DLINE_DEPTH));
        w_status     = {r_err_rxer,
                        r_nib_hi,
                        (r_byte_cnt > CNT_W'(MAX_LEN)),
                        (r_byte_cnt < CNT_W'(MIN_LEN)),
                        (r_crc != CRC_RESIDUE)};
    end

    // Receive FSM with delay line, CRC and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_crc        <= CRC_INIT;
            r_lo_nib     <= '0;
            r_nib_hi     <= 1'b0;
            r_byte_cnt   <= '0;
            r_dline      <= '0;
            r_dline_cnt  <= '0;
            r_first      <= 1'b0;
            r_err_rxer   <= 1'b0;
            Rx_data      <= '0;
            Rx_valid     <= 1'b0;
            Rx_sof       <= 1'b0;
            Rx_eof       <= 1'b0;
            Frame_good   <= 1'b0;
            Frame_status <= '0;
            Frame_len    <= '0;
        end else begin
            Rx_valid <= 1'b0;
            Rx_sof   <= 1'b0;
            Rx_eof   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Rx_dv) begin
                        r_state <= (Rxd == 4'h5) ? S_PREAMBLE : S_DROP;
                    end
                end
                S_PREAMBLE: begin
                    if (!Rx_dv) begin
                        r_state <= S_IDLE;
                    end else if (Rx_er) begin
                        r_state <= S_DROP;
                    end else if (Rxd == 4'h5) begin
                        r_state <= S_PREAMBLE;
                    end else if (Rxd == 4'hD) begin
                        r_state     <= S_DATA;
                        r_crc       <= CRC_INIT;
                        r_nib_hi    <= 1'b0;
                        r_byte_cnt  <= '0;
                        r_dline_cnt <= '0;
                        r_first     <= 1'b1;
                        r_err_rxer  <= 1'b0;
                    end else begin
                        r_state <= S_DROP;
                    end
                end
                S_DATA: begin
                    if (!Rx_dv) begin
                        // Bytes left in the delay line are the FCS and are dropped here.
                        r_state      <= S_IDLE;
                        Rx_eof       <= 1'b1;
                        Frame_status <= w_status;
                        Frame_good   <= (w_status == 5'd0);
                        Frame_len    <= w_len;
                    end else begin
                        r_crc <= w_crc_next;
                        if (Rx_er) begin
                            r_err_rxer <= 1'b1;
                        end
                        if (!r_nib_hi) begin
                            r_lo_nib <= Rxd;
                            r_nib_hi <= 1'b1;
                        end else begin
                            r_nib_hi   <= 1'b0;
                            r_byte_cnt <= w_cnt_inc;
                            r_dline    <= {r_dline[2:0], w_byte};
                            if (w_dline_full) begin
                                Rx_data  <= r_dline[3];
                                Rx_valid <= 1'b1;
                                Rx_sof   <= r_first;
                                r_first  <= 1'b0;
                            end else begin
                                r_dline_cnt <= r_dline_cnt + 3'd1;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (!Rx_dv) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mii_rx_fcs_check.sv
// Bench for mii_rx_fcs_check: drives MII nibble streams and compares the forwarded
// bytes and end-of-frame records with a byte-level reference model.
module tb_mii_rx_fcs_check;

    localparam int unsigned MIN_LEN = 64;
    localparam int unsigned MAX_LEN = 1518;

    typedef logic [7:0] bq_t[$];

    logic        Clk;
    logic        Rst;
    logic        Rx_dv;
    logic        Rx_er;
    logic [3:0]  Rxd;
    logic [7:0]  Rx_data;
    logic        Rx_valid;
    logic        Rx_sof;
    logic        Rx_eof;
    logic        Frame_good;
    logic [4:0]  Frame_status;
    logic [10:0] Frame_len;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mon_bytes[$];
    bit          mon_sof[$];
    logic [16:0] mon_eof_q[$];
    int          mon_bad = 0;
    bit          last_valid = 0;

    logic [7:0]  exp_bytes[$];
    bit          exp_sof[$];
    logic [16:0] exp_eof_q[$];

    mii_rx_fcs_check #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Rx_dv        (Rx_dv),
        .Rx_er        (Rx_er),
        .Rxd          (Rxd),
        .Rx_data      (Rx_data),
        .Rx_valid     (Rx_valid),
        .Rx_sof       (Rx_sof),
        .Rx_eof       (Rx_eof),
        .Frame_good   (Frame_good),
        .Frame_status (Frame_status),
        .Frame_len    (Frame_len)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Collect forwarded bytes and end-of-frame records; flag protocol violations.
    always @(negedge Clk) begin
        if (Rx_valid === 1'b1) begin
            mon_bytes.push_back(Rx_data);
            mon_sof.push_back(Rx_sof === 1'b1);
        end else if (Rx_sof === 1'b1) begin
            mon_bad++;
        end
        if (Rx_eof === 1'b1) begin
            mon_eof_q.push_back({Frame_good, Frame_status, Frame_len});
            if (Rx_valid === 1'b1) mon_bad++;
        end
        if (Rx_valid === 1'b1 && last_valid) mon_bad++;
        last_valid = (Rx_valid === 1'b1);
    end

    // Reference CRC-32 in its reflected form, LSB of each byte first.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d, input int n);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < n; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    function automatic bq_t with_fcs(input bq_t p);
        bq_t         w;
        logic [31:0] r;
        w = p;
        r = 32'hFFFFFFFF;
        foreach (p[i]) r = crc_upd(r, p[i], 8);
        r = ~r;
        for (int k = 0; k < 4; k++) w.push_back(r[8*k +: 8]);
        return w;
    endfunction

    function automatic bq_t ramp(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(i));
        return q;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic int byte_errs();
        int e;
        e = (mon_bytes.size() != exp_bytes.size()) ? 1 : 0;
        for (int i = 0; i < mon_bytes.size() && i < exp_bytes.size(); i++)
            if (mon_bytes[i] !== exp_bytes[i] || mon_sof[i] !== exp_sof[i]) e++;
        return e;
    endfunction

    function automatic int eof_errs();
        int e;
        e = (mon_eof_q.size() != exp_eof_q.size()) ? 1 : 0;
        for (int i = 0; i < mon_eof_q.size() && i < exp_eof_q.size(); i++)
            if (mon_eof_q[i] !== exp_eof_q[i]) e++;
        return e;
    endfunction

    task automatic clear_mon();
        mon_bytes.delete(); mon_sof.delete(); mon_eof_q.delete(); mon_bad = 0;
        exp_bytes.delete(); exp_sof.delete(); exp_eof_q.delete();
    endtask

    task automatic drive(input bit dv, input bit er, input logic [3:0] n);
        @(negedge Clk);
        Rx_dv = dv; Rx_er = er; Rxd = n;
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hD);
    endtask

    // Send wire bytes (DA..FCS) and append the model's expectations for them.
    task automatic send_frame(input bq_t w, input int er_nib, input bit extra, input int idle);
        int          tot;
        int          len;
        logic [31:0] r;
        logic [4:0]  st;
        send_preamble();
        for (int i = 0; i < w.size(); i++) begin
            drive(1'b1, er_nib == 2*i,     w[i][3:0]);
            drive(1'b1, er_nib == 2*i + 1, w[i][7:4]);
        end
        if (extra) drive(1'b1, 1'b0, 4'h6);
        tot = w.size();
        for (int i = 0; i < tot - 4; i++) begin
            exp_bytes.push_back(w[i]);
            exp_sof.push_back(i == 0);
        end
        r = 32'hFFFFFFFF;
        foreach (w[i]) r = crc_upd(r, w[i], 8);
        if (extra) r = crc_upd(r, 8'h06, 4);
        st  = {er_nib >= 0, extra, tot > int'(MAX_LEN), tot < int'(MIN_LEN), r != 32'hDEBB20E3};
        len = (tot < 4) ? 0 : ((tot - 4 > 2047) ? 2047 : tot - 4);
        exp_eof_q.push_back({st == 5'd0, st, 11'(len)});
        for (int i = 0; i < idle; i++) drive(1'b0, 1'b0, 4'h0);
    endtask

    task automatic test_reset();
        Rst = 1'b1; Rx_dv = 1'b0; Rx_er = 1'b0; Rxd = 4'h0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if ({Rx_valid, Rx_sof, Rx_eof, Rx_data} !== 11'd0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 0", {Rx_valid, Rx_sof, Rx_eof, Rx_data});
        end
        n_checks++;
        if ({Frame_good, Frame_status, Frame_len} !== 17'd0) begin
            n_fail++; $display("FAIL reset_status: got %h want 0", {Frame_good, Frame_status, Frame_len});
        end
        Rst = 1'b0;
    endtask

    task automatic test_good_frame();
        clear_mon();
        send_frame(with_fcs(ramp(60)), -1, 1'b0, 3);
        n_checks++;
        if (mon_eof_q.size() != 1 || mon_eof_q[0] !== {1'b1, 5'b00000, 11'd60}) begin
            n_fail++; $display("FAIL good_eof: got %0d records first %h want 1 record %h",
                               mon_eof_q.size(), mon_eof_q.size() > 0 ? mon_eof_q[0] : 17'h0, {1'b1, 5'b0, 11'd60});
        end
        n_checks++;
        if (byte_errs() != 0) begin
            n_fail++; $display("FAIL good_bytes: %0d errors, got %0d bytes want %0d", byte_errs(), mon_bytes.size(), exp_bytes.size());
        end
        n_checks++;
        if (mon_bad != 0) begin
            n_fail++; $display("FAIL good_protocol: got %0d violations want 0", mon_bad);
        end
    endtask

    task automatic test_crc_vector();
        bq_t w;
        w = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        clear_mon();
        send_frame(w, -1, 1'b0, 3);
        n_checks++;
        if (mon_eof_q.size() != 1 || mon_eof_q[0] !== {1'b0, 5'b00010, 11'd9}) begin
            n_fail++; $display("FAIL crc_vector_eof: got %0d records first %h want %h",
                               mon_eof_q.size(), mon_eof_q.size() > 0 ? mon_eof_q[0] : 17'h0, {1'b0, 5'b00010, 11'd9});
        end
        n_checks++;
        if (byte_errs() != 0) begin
            n_fail++; $display("FAIL crc_vector_bytes: %0d errors, got %0d bytes want 9", byte_errs(), mon_bytes.size());
        end
    endtask

    task automatic test_corrupt();
        bq_t w;
        w = with_fcs(ramp(60));
        w[10] = 8'hFF;
        clear_mon();
        send_frame(w, -1, 1'b0, 3);
        n_checks++;
        if (mon_eof_q.size() != 1 || mon_eof_q[0] !== {1'b0, 5'b00001, 11'd60}) begin
            n_fail++; $display("FAIL corrupt_eof: got %0d records first %h want %h",
                               mon_eof_q.size(), mon_eof_q.size() > 0 ? mon_eof_q[0] : 17'h0, {1'b0, 5'b00001, 11'd60});
        end
        n_checks++;
        if (byte_errs() != 0) begin
            n_fail++; $display("FAIL corrupt_bytes: %0d errors, got %0d bytes want 60", byte_errs(), mon_bytes.size());
        end
    endtask

    task automatic test_rxer_align();
        clear_mon();
        send_frame(with_fcs(rand_bytes(60)), 41, 1'b0, 3);
        send_frame(with_fcs(rand_bytes(70)), -1, 1'b1, 3);
        n_checks++;
        if (mon_eof_q.size() != 2 || mon_eof_q[0][16:11] !== 6'b010000 || mon_eof_q[1][14] !== 1'b1) begin
            n_fail++; $display("FAIL rxer_align_flags: got %0d records %h/%h want rxer then align",
                               mon_eof_q.size(), mon_eof_q.size() > 0 ? mon_eof_q[0] : 17'h0,
                               mon_eof_q.size() > 1 ? mon_eof_q[1] : 17'h0);
        end
        n_checks++;
        if (eof_errs() != 0) begin
            n_fail++; $display("FAIL rxer_align_model: %0d record errors, got %0d records want %0d", eof_errs(), mon_eof_q.size(), exp_eof_q.size());
        end
        n_checks++;
        if (byte_errs() != 0) begin
            n_fail++; $display("FAIL rxer_align_bytes: %0d errors, got %0d bytes want %0d", byte_errs(), mon_bytes.size(), exp_bytes.size());
        end
    endtask

    task automatic test_oversize();
        clear_mon();
        send_frame(with_fcs(rand_bytes(1596)), -1, 1'b0, 3);
        n_checks++;
        if (mon_eof_q.size() != 1 || mon_eof_q[0] !== {1'b0, 5'b00100, 11'd1596}) begin
            n_fail++; $display("FAIL oversize_eof: got %0d records first %h want %h",
                               mon_eof_q.size(), mon_eof_q.size() > 0 ? mon_eof_q[0] : 17'h0, {1'b0, 5'b00100, 11'd1596});
        end
        n_checks++;
        if (byte_errs() != 0) begin
            n_fail++; $display("FAIL oversize_bytes: %0d errors, got %0d bytes want 1596", byte_errs(), mon_bytes.size());
        end
    endtask

    task automatic test_preamble_reset();
        bq_t w;
        clear_mon();
        drive(1'b1, 1'b0, 4'h5); drive(1'b1, 1'b0, 4'h5); drive(1'b1, 1'b0, 4'h5); drive(1'b1, 1'b0, 4'h7);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 4'($urandom));
        repeat (3) drive(1'b0, 1'b0, 4'h0);
        n_checks++;
        if (mon_bytes.size() != 0 || mon_eof_q.size() != 0) begin
            n_fail++; $display("FAIL bad_preamble: got %0d bytes %0d eofs want 0 0", mon_bytes.size(), mon_eof_q.size());
        end
        // Prime the status outputs with a good frame, then reset in the middle of the next.
        send_frame(with_fcs(ramp(60)), -1, 1'b0, 3);
        w = with_fcs(ramp(60));
        clear_mon();
        send_preamble();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, w[i][3:0]);
            drive(1'b1, 1'b0, w[i][7:4]);
        end
        drive(1'b1, 1'b0, w[20][3:0]);
        Rst = 1'b1;
        drive(1'b1, 1'b0, w[20][7:4]);
        Rst = 1'b0;
        n_checks++;
        if ({Rx_valid, Rx_sof, Rx_eof, Rx_data, Frame_good, Frame_status, Frame_len} !== 28'd0) begin
            n_fail++; $display("FAIL midframe_reset_outputs: got %h want 0",
                               {Rx_valid, Rx_sof, Rx_eof, Rx_data, Frame_good, Frame_status, Frame_len});
        end
        for (int i = 21; i < w.size(); i++) begin
            drive(1'b1, 1'b0, w[i][3:0]);
            drive(1'b1, 1'b0, w[i][7:4]);
        end
        repeat (3) drive(1'b0, 1'b0, 4'h0);
        n_checks++;
        if (mon_eof_q.size() != 0) begin
            n_fail++; $display("FAIL midframe_reset_eof: got %0d eofs want 0", mon_eof_q.size());
        end
        clear_mon();
        send_frame(with_fcs(ramp(60)), -1, 1'b0, 3);
        n_checks++;
        if (mon_eof_q.size() != 1 || mon_eof_q[0] !== {1'b1, 5'b00000, 11'd60} || byte_errs() != 0) begin
            n_fail++; $display("FAIL after_reset_frame: got %0d records first %h, %0d byte errors want good len 60",
                               mon_eof_q.size(), mon_eof_q.size() > 0 ? mon_eof_q[0] : 17'h0, byte_errs());
        end
    endtask

    task automatic test_random();
        bq_t w;
        int  mode;
        int  er;
        bit  ex;
        clear_mon();
        for (int f = 0; f < 12; f++) begin
            mode = int'($urandom_range(0, 4));
            er   = -1;
            ex   = 1'b0;
            if (mode == 4) begin
                w = rand_bytes(int'($urandom_range(1, 4)));
            end else begin
                w = with_fcs(rand_bytes(int'($urandom_range(1, 80))));
            end
            if (mode == 1) w[$urandom_range(0, w.size() - 1)] ^= 8'(int'($urandom_range(1, 255)));
            if (mode == 2) er = int'($urandom_range(0, 2 * w.size() - 1));
            if (mode == 3) ex = 1'b1;
            send_frame(w, er, ex, int'($urandom_range(1, 4)));
        end
        repeat (3) drive(1'b0, 1'b0, 4'h0);
        n_checks++;
        if (eof_errs() != 0) begin
            n_fail++; $display("FAIL random_eof: %0d record errors, got %0d records want %0d", eof_errs(), mon_eof_q.size(), exp_eof_q.size());
        end
        n_checks++;
        if (byte_errs() != 0) begin
            n_fail++; $display("FAIL random_bytes: %0d errors, got %0d bytes want %0d", byte_errs(), mon_bytes.size(), exp_bytes.size());
        end
        n_checks++;
        if (mon_bad != 0) begin
            n_fail++; $display("FAIL random_protocol: got %0d violations want 0", mon_bad);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(with_fcs(ramp(60)), -1, 1'b0, 1);
        send_frame(with_fcs(rand_bytes(30)), -1, 1'b0, 1);
        send_frame(with_fcs(rand_bytes(64)), -1, 1'b0, 3);
        n_checks++;
        if (mon_eof_q.size() != 3 || eof_errs() != 0) begin
            n_fail++; $display("FAIL b2b_eof: got %0d records (%0d errors) want 3", mon_eof_q.size(), eof_errs());
        end
        n_checks++;
        if (byte_errs() != 0) begin
            n_fail++; $display("FAIL b2b_bytes: %0d errors, got %0d bytes want %0d", byte_errs(), mon_bytes.size(), exp_bytes.size());
        end
        n_checks++;
        if (mon_bad != 0) begin
            n_fail++; $display("FAIL b2b_protocol: got %0d violations want 0", mon_bad);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_vector();
        test_corrupt();
        test_rxer_align();
        test_oversize();
        test_preamble_reset();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
